imm_extend_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 16→32 sign extender.
- Extends an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper/LUI-style, branch-offset (sign-extend then ×4).
- Sits between decode and execute, behind a valid/ready handshake with a 2-entry skid buffer:
  - full throughput;
  - registered in_ready;
  - 1-cycle latency.
- Carries a TAG_W-bit sideband tag (e.g. instruction ID) alongside each result.

---
 rtl/imm_extend_pipe_pkg.sv | 14 +
 rtl/imm_extend_core.sv | 33 +++
 rtl/imm_extend_pipe.sv | 145 ++++++++++++++
 tb/tb_imm_extend_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the pipelined immediate extender: mode encoding
// and its width.
package imm_pkg;

  localparam int IMM_MODE_W = 2;

  typedef enum logic [IMM_MODE_W-1:0] {
    IMM_SIGN   = 2'b00,
    IMM_ZERO   = 2'b01,
    IMM_UPPER  = 2'b10,
    IMM_BRANCH = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: selects sign, zero, upper (LUI-style)
// or branch-offset (sign-extend then x4) formatting of an IN_W-bit immediate.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       imm,
  input  logic [IMM_MODE_W-1:0] mode,
  output logic [OUT_W-1:0]      data
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  assign sext = {{EXT_W{imm[IN_W-1]}}, imm};

  // Mode mux; branch drops the top two bits of the sign-extended value,
  // which are copies of the sign bit because OUT_W >= IN_W+2.
  always_comb begin
    data = {OUT_W{1'b0}};
    case (imm_mode_e'(mode))
      IMM_SIGN:   data = sext;
      IMM_ZERO:   data = {{EXT_W{1'b0}}, imm};
      IMM_UPPER:  data = {imm, {EXT_W{1'b0}}};
      IMM_BRANCH: data = {sext[OUT_W-3:0], 2'b00};
      default:    data = {OUT_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender between decode and execute. A main register
// drives the outputs and a skid register absorbs one extra entry so that
// in_ready can be a plain register while still sustaining full throughput.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_neg
);

  if (IN_W < 1 || TAG_W < 1 || OUT_W < IN_W + 2) begin : g_param_check
    $fatal(1, "imm_extend_pipe: need IN_W>=1, TAG_W>=1, OUT_W>=IN_W+2");
  end

  // Main (m_*) and skid (s_*) storage
  logic             m_valid, s_valid;
  logic [OUT_W-1:0] m_data, s_data;
  logic [TAG_W-1:0] m_tag, s_tag;
  logic             m_neg, s_neg;

  // Next-state values
  logic             m_valid_n, s_valid_n;
  logic [OUT_W-1:0] m_data_n, s_data_n;
  logic [TAG_W-1:0] m_tag_n, s_tag_n;
  logic             m_neg_n, s_neg_n;

  logic [OUT_W-1:0] ext_data;
  logic             accept;
  logic             drain;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (ext_data)
  );

  assign accept = in_valid & in_ready;
  assign drain  = m_valid & out_ready;

  // Skid-buffer next-state: decide where an accepted entry lands and what
  // moves forward when the main register drains.
  always_comb begin
    m_valid_n = m_valid;
    m_data_n  = m_data;
    m_tag_n   = m_tag;
    m_neg_n   = m_neg;
    s_valid_n = s_valid;
    s_data_n  = s_data;
    s_tag_n   = s_tag;
    s_neg_n   = s_neg;
    if (flush) begin
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end else if (drain && s_valid) begin
      m_valid_n = 1'b1;
      m_data_n  = s_data;
      m_tag_n   = s_tag;
      m_neg_n   = s_neg;
      if (accept) begin
        s_data_n = ext_data;
        s_tag_n  = in_tag;
        s_neg_n  = ext_data[OUT_W-1];
      end else begin
        s_valid_n = 1'b0;
      end
    end else if (drain) begin
      if (accept) begin
        m_data_n = ext_data;
        m_tag_n  = in_tag;
        m_neg_n  = ext_data[OUT_W-1];
      end else begin
        m_valid_n = 1'b0;
      end
    end else if (m_valid) begin
      // Stalled: in_ready high implies the skid slot is free.
      if (accept) begin
        s_valid_n = 1'b1;
        s_data_n  = ext_data;
        s_tag_n   = in_tag;
        s_neg_n   = ext_data[OUT_W-1];
      end else begin
        s_valid_n = s_valid;
      end
    end else begin
      if (accept) begin
        m_valid_n = 1'b1;
        m_data_n  = ext_data;
        m_tag_n   = in_tag;
        m_neg_n   = ext_data[OUT_W-1];
      end else begin
        m_valid_n = m_valid;
      end
    end
  end

  // State registers; in_ready tracks the inverse of the next skid valid so
  // it always comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_tag    <= '0;
      m_neg    <= 1'b0;
      s_valid  <= 1'b0;
      s_data   <= '0;
      s_tag    <= '0;
      s_neg    <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      m_valid  <= m_valid_n;
      m_data   <= m_data_n;
      m_tag    <= m_tag_n;
      m_neg    <= m_neg_n;
      s_valid  <= s_valid_n;
      s_data   <= s_data_n;
      s_tag    <= s_tag_n;
      s_neg    <= s_neg_n;
      in_ready <= ~s_valid_n;
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_tag   = m_tag;
  assign out_neg   = m_neg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: modes, streaming, backpressure, flush,
// async reset, plus a narrow-parameter instance.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_neg;

  logic        p_flush;
  logic        p_in_valid;
  logic        p_in_ready;
  logic [11:0] p_in_imm;
  logic [1:0]  p_in_mode;
  logic [3:0]  p_in_tag;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [19:0] p_out_data;
  logic [3:0]  p_out_tag;
  logic        p_out_neg;

  int n_tests = 0;
  int n_fail  = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_neg(out_neg)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(4)) dut_p (
    .clk(clk), .rst_n(rst_n), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm),
    .in_mode(p_in_mode), .in_tag(p_in_tag),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .out_tag(p_out_tag), .out_neg(p_out_neg)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for one edge, then drop in_valid
  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [3:0] tag);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
    in_imm   = 16'hxxxx;
    in_mode  = 2'bxx;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = 16'h0000;
    in_mode = 2'b00; in_tag = 4'h0; out_ready = 1'b1;
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_imm = 12'h000; p_in_mode = 2'b00;
    p_in_tag = 4'h0; p_out_ready = 1'b1;
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_tag", {28'd0, out_tag}, 32'd0);
    check_eq("rst_out_neg", {31'd0, out_neg}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Modes, one cycle after accept; X on idle inputs
    send(16'h8004, 2'b00, 4'h1);
    check_eq("sign_valid", {31'd0, out_valid}, 32'd1);
    check_eq("sign_data", out_data, 32'hFFFF8004);
    check_eq("sign_neg", {31'd0, out_neg}, 32'd1);
    check_eq("sign_tag", {28'd0, out_tag}, 32'd1);
    send(16'h8004, 2'b01, 4'h2);
    check_eq("zero_data", out_data, 32'h00008004);
    check_eq("zero_neg", {31'd0, out_neg}, 32'd0);
    send(16'h8004, 2'b10, 4'h3);
    check_eq("upper_data", out_data, 32'h80040000);
    check_eq("upper_neg", {31'd0, out_neg}, 32'd1);
    send(16'h8004, 2'b11, 4'h4);
    check_eq("branch_data", out_data, 32'hFFFE0010);
    check_eq("branch_tag", {28'd0, out_tag}, 32'd4);
    tick();
    check_eq("idle_valid", {31'd0, out_valid}, 32'd0);

    // Streaming: 8 back-to-back accepts
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'(i);
      in_mode  = 2'b01;
      in_tag   = 4'(i);
      check_eq("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check_eq("stream_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stream_tag", {28'd0, out_tag}, 32'(i));
      check_eq("stream_data", out_data, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b00; in_tag = 4'h1;
    tick();
    check_eq("bp_first_ready", {31'd0, in_ready}, 32'd1);
    in_imm = 16'hFFFF; in_mode = 2'b01; in_tag = 4'h2;
    tick();
    check_eq("bp_ready_fell", {31'd0, in_ready}, 32'd0);
    check_eq("bp_hold_data", out_data, 32'h00001234);
    check_eq("bp_hold_tag", {28'd0, out_tag}, 32'd1);
    in_imm = 16'h0010; in_mode = 2'b11; in_tag = 4'h3;
    tick();
    tick();
    check_eq("bp_stable_data", out_data, 32'h00001234);
    check_eq("bp_stable_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_rel_tag2", {28'd0, out_tag}, 32'd2);
    check_eq("bp_rel_data2", out_data, 32'h0000FFFF);
    check_eq("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("bp_rel_tag3", {28'd0, out_tag}, 32'd3);
    check_eq("bp_rel_data3", out_data, 32'h00000040);
    in_valid = 1'b0;
    tick();
    check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush with M and S full and a request pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0005; in_mode = 2'b00; in_tag = 4'h4;
    tick();
    in_tag = 4'h5;
    tick();
    check_eq("fl_full_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_tag = 4'h6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    check_eq("fl_still_empty", {31'd0, out_valid}, 32'd0);
    send(16'h0001, 2'b00, 4'h7);
    check_eq("fl_after_data", out_data, 32'h00000001);
    check_eq("fl_after_tag", {28'd0, out_tag}, 32'd7);

    // Async reset between clock edges
    in_valid = 1'b1; in_imm = 16'hABCD; in_mode = 2'b01; in_tag = 4'h9;
    tick();
    check_eq("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ar_out_data", out_data, 32'h0);
    check_eq("ar_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("ar_idle", {31'd0, out_valid}, 32'd0);
    send(16'h7FFF, 2'b11, 4'hA);
    check_eq("ar_after_data", out_data, 32'h0001FFFC);
    check_eq("ar_after_neg", {31'd0, out_neg}, 32'd0);

    // Narrow parameter instance
    p_in_valid = 1'b1; p_in_imm = 12'hFFF; p_in_mode = 2'b11; p_in_tag = 4'h1;
    tick();
    check_eq("p_branch_data", {12'd0, p_out_data}, 32'h000FFFFC);
    check_eq("p_branch_neg", {31'd0, p_out_neg}, 32'd1);
    p_in_imm = 12'h800; p_in_mode = 2'b10; p_in_tag = 4'h2;
    tick();
    p_in_valid = 1'b0;
    check_eq("p_upper_data", {12'd0, p_out_data}, 32'h00080000);
    check_eq("p_upper_tag", {28'd0, p_out_tag}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
